spad_w_loader: RTL

//  Write-side sequencer for the weight scratchpad (the SPAD_W module).
//  - Accepts a valid/ready stream of signed weights.
//  - Drives the scratchpad write port (we_en / addr_we / data_in), one word per cycle from address 0.
//  - Flags the PE when the weight set is resident; holds it until the PE releases it.
//  - Sits between the weight DMA/stream and one PE's SPAD_W instance.

---
 rtl/spad_w_loader_if.sv | 25 ++
 rtl/spad_w_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/spad_w_loader_if.sv
// Stream-in and scratchpad write-port bundle for the weight loader.
// master: loader side (consumes the stream, drives SPAD_W); slave: stream source / SPAD_W side.
interface spad_w_loader_if #(
    parameter int unsigned WEIGHT_DW = 32,
    parameter int unsigned DEPTH     = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                 s_valid;
    logic [WEIGHT_DW-1:0] s_data;
    logic                 s_ready;
    logic                 spad_we_en;
    logic [AW-1:0]        spad_addr_we;
    logic [WEIGHT_DW-1:0] spad_data_in;

    modport master (
        input  s_valid, s_data,
        output s_ready, spad_we_en, spad_addr_we, spad_data_in
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, spad_we_en, spad_addr_we, spad_data_in
    );
endinterface

// File: rtl/spad_w_loader.sv
// Write-side sequencer for one PE's weight scratchpad (SPAD_W).
// Optional macro WLOAD_ZERO_FILL_EN: zero-fill addresses len..DEPTH-1 after a short load.
module spad_w_loader #(
    parameter int unsigned WEIGHT_DW = 32,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [AW:0]          load_len,
    spad_w_loader_if.master      bus,
    output logic                 busy,
    output logic                 w_ready,
    input  logic                 w_release,
    output logic                 len_err
);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        len_q, len_nxt;
    logic [LW-1:0]        addr_q, addr_nxt;
    logic                 we_q, we_nxt;
    logic [AW-1:0]        waddr_q, waddr_nxt;
    logic [WEIGHT_DW-1:0] wdata_q, wdata_nxt;
    logic                 w_ready_nxt;
    logic                 len_err_nxt;
    logic                 accept;
    logic                 len_ok;

    // s_ready and busy are state decodes; everything else below is registered
    assign bus.s_ready      = (state == ST_LOAD);
    assign busy             = (state != ST_IDLE);
    assign bus.spad_we_en   = we_q;
    assign bus.spad_addr_we = waddr_q;
    assign bus.spad_data_in = wdata_q;

    assign accept = bus.s_valid && (state == ST_LOAD);
    assign len_ok = (load_len != '0) && (load_len <= LW'(DEPTH));

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            len_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            w_ready <= 1'b0;
            len_err <= 1'b0;
        end else begin
            len_q   <= len_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            waddr_q <= waddr_nxt;
            wdata_q <= wdata_nxt;
            w_ready <= w_ready_nxt;
            len_err <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        addr_nxt    = addr_q;
        we_nxt      = 1'b0;
        waddr_nxt   = waddr_q;
        wdata_nxt   = wdata_q;
        w_ready_nxt = w_ready;
        len_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    if (len_ok) begin
                        len_nxt   = load_len;
                        addr_nxt  = '0;
                        state_nxt = ST_LOAD;
                    end else begin
                        len_err_nxt = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = AW'(addr_q);
                    wdata_nxt = bus.s_data;
                    addr_nxt  = addr_q + LW'(1);
                    if (addr_q + LW'(1) == len_q) begin
`ifdef WLOAD_ZERO_FILL_EN
                        state_nxt = (len_q < LW'(DEPTH)) ? ST_FILL : ST_DONE;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end

`ifdef WLOAD_ZERO_FILL_EN
            // Overwrite the tail so stale weights from a longer set never reach the PE
            ST_FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = AW'(addr_q);
                wdata_nxt = '0;
                addr_nxt  = addr_q + LW'(1);
                if (addr_q == LW'(DEPTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
`endif

            // Wait one quiet write cycle so the last negedge write into SPAD_W has landed
            ST_DONE: begin
                if (w_ready) begin
                    if (w_release) begin
                        w_ready_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                end else if (!we_q) begin
                    w_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule
